// File: rtl/ttt_pkg.sv
// ttt_pkg: shared marks, cell codes, FSM states and win-line table for the TicTacToe controller.
package ttt_pkg;
    localparam logic [1:0] EMPTY   = 2'b00;
    localparam logic [1:0] MARK_X  = 2'b01;
    localparam logic [1:0] MARK_O  = 2'b10;
    localparam logic [1:0] DRAW    = 2'b11;
    localparam logic [3:0] NO_CELL = 4'd15;

    typedef enum logic [1:0] {S_WAIT, S_CHECK, S_EVAL, S_OVER} state_t;

    // rows, columns, then the two diagonals
    localparam logic [3:0] WIN_LINES [8][3] = '{
        '{4'd0, 4'd1, 4'd2}, '{4'd3, 4'd4, 4'd5}, '{4'd6, 4'd7, 4'd8},
        '{4'd0, 4'd3, 4'd6}, '{4'd1, 4'd4, 4'd7}, '{4'd2, 4'd5, 4'd8},
        '{4'd0, 4'd4, 4'd8}, '{4'd2, 4'd4, 4'd6}
    };
endpackage

// File: rtl/ttt_move_controller_if.sv
// ttt_move_controller_if: mouse inputs and board/game-state outputs of the move controller.
interface ttt_move_controller_if;
    logic [9:0]  posX;
    logic [8:0]  posY;
    logic [2:0]  buttons;
    logic [17:0] board;
    logic [3:0]  hover_cell;
    logic        turn;
    logic [1:0]  winner;
    logic        game_over;
    logic        move_accept;
    logic        move_reject;

    modport master (
        output posX, posY, buttons,
        input  board, hover_cell, turn, winner, game_over, move_accept, move_reject
    );
    modport slave (
        input  posX, posY, buttons,
        output board, hover_cell, turn, winner, game_over, move_accept, move_reject
    );
endinterface

// File: rtl/ttt_cell_decoder.sv
// ttt_cell_decoder: registered cursor-to-cell map using compares only; 15 when off-board.
module ttt_cell_decoder
    import ttt_pkg::*;
#(
    parameter int unsigned BOARD_X0 = 170,
    parameter int unsigned BOARD_Y0 = 90,
    parameter int unsigned CELL     = 100
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] i_pos_x,
    input  logic [8:0] i_pos_y,
    output logic [3:0] o_hover_cell
);
    localparam logic [10:0] X0 = 11'(BOARD_X0);
    localparam logic [10:0] X1 = 11'(BOARD_X0 + CELL);
    localparam logic [10:0] X2 = 11'(BOARD_X0 + 2 * CELL);
    localparam logic [10:0] X3 = 11'(BOARD_X0 + 3 * CELL);
    localparam logic [10:0] Y0 = 11'(BOARD_Y0);
    localparam logic [10:0] Y1 = 11'(BOARD_Y0 + CELL);
    localparam logic [10:0] Y2 = 11'(BOARD_Y0 + 2 * CELL);
    localparam logic [10:0] Y3 = 11'(BOARD_Y0 + 3 * CELL);

    logic [10:0] w_x, w_y;
    logic [1:0]  w_col, w_row;
    logic        w_on_board;
    logic [3:0]  w_cell;
    logic [3:0]  r_hover;

    assign w_x        = {1'b0, i_pos_x};
    assign w_y        = {2'b0, i_pos_y};
    assign w_col      = (w_x < X1) ? 2'd0 : (w_x < X2) ? 2'd1 : 2'd2;
    assign w_row      = (w_y < Y1) ? 2'd0 : (w_y < Y2) ? 2'd1 : 2'd2;
    assign w_on_board = (w_x >= X0) && (w_x < X3) && (w_y >= Y0) && (w_y < Y3);
    assign w_cell     = {2'b0, w_row} + {1'b0, w_row, 1'b0} + {2'b0, w_col};

    always_ff @(posedge clk or negedge reset)
        if (!reset) r_hover <= NO_CELL;
        else        r_hover <= w_on_board ? w_cell : NO_CELL;

    assign o_hover_cell = r_hover;
endmodule

// File: rtl/ttt_move_controller.sv
// ttt_move_controller: turns mouse clicks into TicTacToe moves, alternates players,
// detects win/draw and owns the board; right-click starts a new game.
module ttt_move_controller
    import ttt_pkg::*;
#(
    parameter int unsigned BOARD_X0 = 170,
    parameter int unsigned BOARD_Y0 = 90,
    parameter int unsigned CELL     = 100
) (
    input logic                  clk,
    input logic                  reset,
    ttt_move_controller_if.slave bus
);
    state_t          r_state, w_state_n;
    logic [8:0][1:0] r_board, w_board_n;
    logic [3:0]      r_cell, w_cell_n;
    logic [3:0]      r_cnt, w_cnt_n;
    logic [1:0]      r_winner, w_winner_n;
    logic [1:0]      r_btn_q;
    logic            r_turn, w_turn_n;
    logic            r_over, w_over_n;
    logic            r_acc, w_acc_n;
    logic            r_rej, w_rej_n;
    logic [3:0]      w_hover;
    logic [1:0]      w_win;
    logic            w_left, w_right;
    logic            w_unused;

    ttt_cell_decoder #(.BOARD_X0(BOARD_X0), .BOARD_Y0(BOARD_Y0), .CELL(CELL)) u_dec (
        .clk          (clk),
        .reset        (reset),
        .i_pos_x      (bus.posX),
        .i_pos_y      (bus.posY),
        .o_hover_cell (w_hover)
    );

    assign w_left   = bus.buttons[0] & ~r_btn_q[0];
    assign w_right  = bus.buttons[1] & ~r_btn_q[1];
    assign w_unused = bus.buttons[2];

    always_comb begin
        w_win = EMPTY;
        for (int k = 0; k < 8; k++)
            w_win = (r_board[WIN_LINES[k][0]] != EMPTY &&
                     r_board[WIN_LINES[k][0]] == r_board[WIN_LINES[k][1]] &&
                     r_board[WIN_LINES[k][0]] == r_board[WIN_LINES[k][2]])
                    ? r_board[WIN_LINES[k][0]] : w_win;
    end

    always_comb begin
        w_state_n  = r_state;
        w_board_n  = r_board;
        w_cell_n   = r_cell;
        w_cnt_n    = r_cnt;
        w_winner_n = r_winner;
        w_turn_n   = r_turn;
        w_over_n   = r_over;
        w_acc_n    = 1'b0;
        w_rej_n    = 1'b0;
        if (w_right) begin
            w_state_n  = S_WAIT;
            w_board_n  = '0;
            w_cnt_n    = 4'd0;
            w_winner_n = EMPTY;
            w_turn_n   = 1'b0;
            w_over_n   = 1'b0;
        end else begin
            case (r_state)
                S_WAIT: if (w_left) begin
                    w_cell_n  = w_hover;
                    w_state_n = S_CHECK;
                end
                S_CHECK: if (r_cell > 4'd8 || r_board[r_cell] != EMPTY) begin
                    w_rej_n   = 1'b1;
                    w_state_n = S_WAIT;
                end else begin
                    w_board_n[r_cell] = r_turn ? MARK_O : MARK_X;
                    w_cnt_n           = (r_cnt == 4'd9) ? 4'd9 : r_cnt + 4'd1;
                    w_acc_n           = 1'b1;
                    w_state_n         = S_EVAL;
                end
                S_EVAL: if (w_win != EMPTY || r_cnt == 4'd9) begin
                    w_winner_n = (w_win != EMPTY) ? w_win : DRAW;
                    w_over_n   = 1'b1;
                    w_state_n  = S_OVER;
                end else begin
                    w_turn_n  = ~r_turn;
                    w_state_n = S_WAIT;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            r_state  <= S_WAIT;
            r_board  <= '0;
            r_cell   <= NO_CELL;
            r_cnt    <= 4'd0;
            r_winner <= EMPTY;
            r_turn   <= 1'b0;
            r_over   <= 1'b0;
            r_acc    <= 1'b0;
            r_rej    <= 1'b0;
            r_btn_q  <= 2'b00;
        end else begin
            r_state  <= w_state_n;
            r_board  <= w_board_n;
            r_cell   <= w_cell_n;
            r_cnt    <= w_cnt_n;
            r_winner <= w_winner_n;
            r_turn   <= w_turn_n;
            r_over   <= w_over_n;
            r_acc    <= w_acc_n;
            r_rej    <= w_rej_n;
            r_btn_q  <= bus.buttons[1:0];
        end

    assign bus.board       = r_board;
    assign bus.hover_cell  = w_hover;
    assign bus.turn        = r_turn;
    assign bus.winner      = r_winner;
    assign bus.game_over   = r_over;
    assign bus.move_accept = r_acc;
    assign bus.move_reject = r_rej;
endmodule

// File: tb/tb_ttt_move_controller.sv
// tb_ttt_move_controller: directed vectors for the cell decoder plus hand-written game sequences.
module tb_ttt_move_controller;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    typedef struct {
        int x;
        int y;
        int hv;
    } vec_t;

    vec_t vecs[15];
    int   draw_seq[9];

    ttt_move_controller_if bus();

    ttt_move_controller #(.BOARD_X0(170), .BOARD_Y0(90), .CELL(100)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Aim at a pixel, press left, sample the pulses across the move window, release.
    task automatic click_xy(input int x, input int y, output int acc, output int rej, output int pulses);
        bus.posX = 10'(x);
        bus.posY = 9'(y);
        tick(1);
        bus.buttons[0] = 1'b1;
        tick(1);
        pulses = int'(bus.move_accept) + int'(bus.move_reject);
        tick(1);
        acc = int'(bus.move_accept);
        rej = int'(bus.move_reject);
        pulses += acc + rej;
        bus.buttons[0] = 1'b0;
        tick(1);
        pulses += int'(bus.move_accept) + int'(bus.move_reject);
        tick(1);
    endtask

    task automatic click_cell(input int c, output int acc, output int rej, output int pulses);
        click_xy(220 + 100 * (c % 3), 140 + 100 * (c / 3), acc, rej, pulses);
    endtask

    task automatic right_click();
        bus.buttons[1] = 1'b1;
        tick(1);
        bus.buttons[1] = 1'b0;
        tick(1);
    endtask

    initial begin
        int acc, rej, pulses, nacc;
        vecs = '{
            '{320, 240, 4},  '{169, 140, 15}, '{170, 140, 0},  '{269, 140, 0},
            '{270, 140, 1},  '{469, 140, 2},  '{470, 140, 15}, '{220, 89, 15},
            '{220, 90, 0},   '{220, 389, 6},  '{220, 390, 15}, '{100, 50, 15},
            '{420, 340, 8},  '{370, 289, 5},  '{369, 290, 7}
        };
        draw_seq = '{0, 1, 2, 4, 3, 5, 7, 6, 8};
        bus.posX = 10'd320;
        bus.posY = 9'd240;
        bus.buttons = 3'b000;

        tick(2);
        chk("reset_hover", int'(bus.hover_cell), 15);
        chk("reset_board", int'(bus.board), 0);

        // async reset in the middle of a move
        rst_n = 1'b1;
        bus.posX = 10'd220;
        bus.posY = 9'd140;
        tick(1);
        bus.buttons[0] = 1'b1;
        tick(2);
        chk("pre_reset_board", int'(bus.board), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_board", int'(bus.board), 0);
        chk("async_hover", int'(bus.hover_cell), 15);
        chk("async_turn", int'(bus.turn), 0);
        chk("async_winner", int'(bus.winner), 0);
        chk("async_over", int'(bus.game_over), 0);
        chk("async_pulses", int'(bus.move_accept) + int'(bus.move_reject), 0);
        bus.buttons = 3'b000;
        tick(1);
        rst_n = 1'b1;
        tick(1);

        foreach (vecs[i]) begin
            bus.posX = 10'(vecs[i].x);
            bus.posY = 9'(vecs[i].y);
            tick(1);
            chk($sformatf("hover_%0d_%0d", vecs[i].x, vecs[i].y), int'(bus.hover_cell), vecs[i].hv);
        end

        // left button held for 50 cycles gives exactly one move
        bus.posX = 10'd220;
        bus.posY = 9'd140;
        tick(1);
        bus.buttons[0] = 1'b1;
        nacc = 0;
        for (int i = 1; i <= 50; i++) begin
            tick(1);
            nacc += int'(bus.move_accept);
            if (i == 2) chk("held_accept_at_2", int'(bus.move_accept), 1);
            if (i == 2) chk("held_board_at_2", int'(bus.board), 1);
            if (i == 2) chk("held_turn_at_2", int'(bus.turn), 0);
            if (i == 3) chk("held_turn_at_3", int'(bus.turn), 1);
        end
        chk("held_accept_count", nacc, 1);
        bus.buttons[0] = 1'b0;
        tick(1);

        click_cell(0, acc, rej, pulses);
        chk("occupied_reject", rej, 1);
        chk("occupied_accept", acc, 0);
        chk("occupied_board", int'(bus.board), 1);
        chk("occupied_turn", int'(bus.turn), 1);
        click_xy(100, 50, acc, rej, pulses);
        chk("offboard_reject", rej, 1);
        chk("offboard_pulses", pulses, 1);
        chk("offboard_turn", int'(bus.turn), 1);

        // O3, X1, O4, X2 completes the top row for X
        click_cell(3, acc, rej, pulses);
        chk("o3_accept", acc, 1);
        click_cell(1, acc, rej, pulses);
        chk("x1_accept", acc, 1);
        click_cell(4, acc, rej, pulses);
        chk("o4_accept", acc, 1);
        chk("pre_win_winner", int'(bus.winner), 0);
        click_cell(2, acc, rej, pulses);
        chk("x2_accept", acc, 1);
        chk("win_board", int'(bus.board), 'h295);
        chk("win_winner", int'(bus.winner), 1);
        chk("win_over", int'(bus.game_over), 1);
        chk("win_turn", int'(bus.turn), 0);
        click_cell(5, acc, rej, pulses);
        chk("over_pulses", pulses, 0);
        chk("over_board", int'(bus.board), 'h295);
        right_click();
        chk("new_board", int'(bus.board), 0);
        chk("new_winner", int'(bus.winner), 0);
        chk("new_turn", int'(bus.turn), 0);
        chk("new_over", int'(bus.game_over), 0);

        foreach (draw_seq[i]) begin
            click_cell(draw_seq[i], acc, rej, pulses);
            chk($sformatf("draw_accept_%0d", i), acc, 1);
            if (i < 8) chk($sformatf("draw_turn_%0d", i), int'(bus.turn), (i + 1) % 2);
            if (i < 8) chk($sformatf("draw_winner_%0d", i), int'(bus.winner), 0);
        end
        chk("draw_board", int'(bus.board), 'h16A59);
        chk("draw_winner", int'(bus.winner), 3);
        chk("draw_over", int'(bus.game_over), 1);
        right_click();
        chk("draw_clear", int'(bus.board), 0);

        // right-click while the move sits in S_CHECK discards it
        bus.posX = 10'd220;
        bus.posY = 9'd140;
        tick(1);
        bus.buttons = 3'b001;
        tick(1);
        bus.buttons = 3'b011;
        tick(1);
        chk("abort_accept", int'(bus.move_accept), 0);
        chk("abort_reject", int'(bus.move_reject), 0);
        chk("abort_board", int'(bus.board), 0);
        bus.buttons = 3'b000;
        tick(3);
        chk("abort_board_late", int'(bus.board), 0);
        chk("abort_turn", int'(bus.turn), 0);
        click_cell(4, acc, rej, pulses);
        chk("after_abort_accept", acc, 1);
        chk("after_abort_board", int'(bus.board), 'h100);
        chk("after_abort_turn", int'(bus.turn), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
